// File: rtl/datapath_sequencer.sv
// Fetch/decode/execute controller for the datapath block: owns the PC, fetches
// instructions over a ready handshake, drives Opcode/RegWrite and keeps the ALU flags.
module datapath_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] MemData,
  input  logic        MemReady,
  input  logic [4:0]  Flags,
  output logic [15:0] MemAddr,
  output logic        MemRead,
  output logic [15:0] Opcode,
  output logic        RegWrite,
  output logic        Cin,
  output logic        Halted,
  output logic [15:0] PC
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StWb, StHalt} state_e;

  // Flag register bit positions
  localparam int unsigned FlagC = 0;
  localparam int unsigned FlagL = 1;
  localparam int unsigned FlagF = 2;
  localparam int unsigned FlagZ = 3;
  localparam int unsigned FlagN = 4;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [4:0]  flags_q, flags_d;

  logic        is_branch;
  logic        is_cmp;
  logic        br_taken;
  logic [15:0] br_target;

  assign is_branch = (ir_q[15:12] == 4'hC);
  assign is_cmp    = (ir_q[15:12] == 4'h0) && (ir_q[7:4] == 4'hB);
  assign br_target = pc_q + {{8{ir_q[7]}}, ir_q[7:0]};

  always_comb begin
    br_taken = 1'b0;
    case (ir_q[11:8])
      4'h0:    br_taken = flags_q[FlagZ];
      4'h1:    br_taken = ~flags_q[FlagZ];
      4'h2:    br_taken = flags_q[FlagC];
      4'h3:    br_taken = ~flags_q[FlagC];
      4'h4:    br_taken = flags_q[FlagL];
      4'h5:    br_taken = ~flags_q[FlagL];
      4'h6:    br_taken = flags_q[FlagN];
      4'h7:    br_taken = ~flags_q[FlagN];
      4'h8:    br_taken = flags_q[FlagF];
      4'h9:    br_taken = ~flags_q[FlagF];
      4'hE:    br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      flags_q <= 5'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    unique case (state_q)
      StFetch: begin
        if (MemReady) begin
          ir_d    = MemData;
          pc_d    = pc_q + 16'd1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (ir_q == 16'hFFFF) begin
          state_d = StHalt;
        end else if (ir_q[15:12] <= 4'hC) begin
          state_d = StExec;
        end else begin
          state_d = StFetch;
        end
      end
      StExec: begin
        if (is_branch) begin
          if (br_taken) pc_d = br_target;
          state_d = StFetch;
        end else begin
          flags_d = Flags;
          state_d = is_cmp ? StFetch : StWb;
        end
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // Outputs depend only on registered state; MemRead is additionally gated by reset.
  always_comb begin
    MemRead  = (state_q == StFetch) && Reset;
    MemAddr  = pc_q;
    PC       = pc_q;
    Cin      = flags_q[FlagC];
    RegWrite = (state_q == StWb);
    Halted   = (state_q == StHalt);
    Opcode   = 16'h0000;
    if ((state_q == StDecode) || (state_q == StExec) || (state_q == StWb)) begin
      Opcode = ir_q;
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: directed scenarios plus a random
// program checked against an instruction-level reference model.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_ready = 1'b0;
  logic [4:0]  flags = 5'b0;
  logic [15:0] mem_data, mem_addr, opcode, pc;
  logic        mem_read, reg_write, cin, halted;
  logic [15:0] mem_data_w, mem_addr_w, opcode_w, pc_w;
  logic        mem_read_w, reg_write_w, cin_w, halted_w;

  logic [15:0] mem [0:65535];

  assign mem_data   = mem[mem_addr];
  assign mem_data_w = mem[mem_addr_w];

  always #5 clk = ~clk;

  datapath_sequencer dut (
    .Clk(clk), .Reset(rst_n), .MemData(mem_data), .MemReady(mem_ready), .Flags(flags),
    .MemAddr(mem_addr), .MemRead(mem_read), .Opcode(opcode), .RegWrite(reg_write),
    .Cin(cin), .Halted(halted), .PC(pc)
  );

  datapath_sequencer #(.RESET_PC(16'hFFFF)) dut_w (
    .Clk(clk), .Reset(rst_n), .MemData(mem_data_w), .MemReady(mem_ready), .Flags(flags),
    .MemAddr(mem_addr_w), .MemRead(mem_read_w), .Opcode(opcode_w), .RegWrite(reg_write_w),
    .Cin(cin_w), .Halted(halted_w), .PC(pc_w)
  );

  int          n_total = 0;
  int          n_bad = 0;
  logic [15:0] mpc;
  logic [4:0]  mflags;
  logic        use_fixed = 1'b0;
  logic [4:0]  fixed_flags = 5'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_cycle(input logic exp_read, input logic [15:0] exp_op,
                             input logic exp_rw, input logic exp_halt);
    check_eq("mem_read", 32'(mem_read), 32'(exp_read));
    check_eq("mem_addr", 32'(mem_addr), 32'(mpc));
    check_eq("pc", 32'(pc), 32'(mpc));
    check_eq("opcode", 32'(opcode), 32'(exp_op));
    check_eq("reg_write", 32'(reg_write), 32'(exp_rw));
    check_eq("halted", 32'(halted), 32'(exp_halt));
    check_eq("cin", 32'(cin), 32'(mflags[0]));
  endtask

  // Branch condition table: flags are {N, Z, F, L, C}
  function automatic logic cond_true(input logic [3:0] c, input logic [4:0] f);
    case (c)
      4'h0: return f[3];
      4'h1: return !f[3];
      4'h2: return f[0];
      4'h3: return !f[0];
      4'h4: return f[1];
      4'h5: return !f[1];
      4'h6: return f[4];
      4'h7: return !f[4];
      4'h8: return f[2];
      4'h9: return !f[2];
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] gen_instr();
    logic [15:0] w;
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r <= 5)      w = {4'($urandom_range(0, 11)), 12'($urandom)};
    else if (r == 6) w = {4'h0, 4'($urandom), 4'hB, 4'($urandom)};
    else if (r <= 8) w = {4'hC, 12'($urandom)};
    else             w = {4'($urandom_range(13, 15)), 12'($urandom)};
    if (w == 16'hFFFF) w = 16'hFFFE;
    return w;
  endfunction

  // Runs one instruction from its first fetch cycle to the start of the next fetch.
  task automatic run_instr(input int waits);
    int          nw;
    logic [15:0] ir;
    logic [4:0]  fl;
    nw = (waits < 0) ? int'($urandom_range(0, 2)) : waits;
    for (int i = 0; i <= nw; i++) begin
      check_cycle(1'b1, 16'h0, 1'b0, 1'b0);
      mem_ready = (i == nw);
      flags = 5'($urandom);
      @(negedge clk);
    end
    ir  = mem[mpc];
    mpc = mpc + 16'd1;
    check_cycle(1'b0, ir, 1'b0, 1'b0);
    mem_ready = 1'($urandom);
    flags = 5'($urandom);
    @(negedge clk);
    if (ir == 16'hFFFF) begin
      repeat (6) begin
        check_cycle(1'b0, 16'h0, 1'b0, 1'b1);
        mem_ready = 1'b1;
        @(negedge clk);
      end
      return;
    end
    if (ir[15:12] > 4'hC) return;
    check_cycle(1'b0, ir, 1'b0, 1'b0);
    fl = use_fixed ? fixed_flags : 5'($urandom);
    flags = fl;
    mem_ready = 1'($urandom);
    @(negedge clk);
    if (ir[15:12] == 4'hC) begin
      if (cond_true(ir[11:8], mflags)) mpc = mpc + {{8{ir[7]}}, ir[7:0]};
    end else begin
      mflags = fl;
      if (!(ir[15:12] == 4'h0 && ir[7:4] == 4'hB)) begin
        check_cycle(1'b0, ir, 1'b1, 1'b0);
        mem_ready = 1'($urandom);
        @(negedge clk);
      end
    end
  endtask

  // Called at a falling edge; returns 1 ns after reset release.
  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("rst_mem_read", 32'(mem_read), 32'd0);
      check_eq("rst_pc", 32'(pc), 32'd0);
      check_eq("rst_opcode", 32'(opcode), 32'd0);
      check_eq("rst_halted", 32'(halted), 32'd0);
      check_eq("rst_reg_write", 32'(reg_write), 32'd0);
      check_eq("rst_cin", 32'(cin), 32'd0);
      check_eq("rst_addr_w", 32'(mem_addr_w), 32'hFFFF);
      @(negedge clk);
    end
    rst_n = 1'b1;
    #1;
    check_eq("rel_mem_read", 32'(mem_read), 32'd1);
    check_eq("rel_mem_addr", 32'(mem_addr), 32'd0);
    mpc    = 16'h0000;
    mflags = 5'b0;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'hD000;
    @(negedge clk);

    // ALU write op, zero-wait
    do_reset();
    mem[0] = 16'h0152;
    run_instr(0);
    check_eq("alu_next_addr", 32'(mem_addr), 32'd1);
    run_instr(0);

    // CMP sets Z, BEQ -2 taken
    do_reset();
    mem[0] = 16'h01B2;
    mem[1] = 16'hC0FE;
    use_fixed = 1'b1;
    fixed_flags = 5'b01000;
    run_instr(0);
    run_instr(0);
    check_eq("beq_taken_addr", 32'(mem_addr), 32'd0);

    // CMP clears Z, BEQ not taken
    do_reset();
    fixed_flags = 5'b00000;
    run_instr(0);
    run_instr(0);
    check_eq("beq_not_taken_addr", 32'(mem_addr), 32'd2);
    use_fixed = 1'b0;

    // Wait states on fetch
    do_reset();
    mem[0] = 16'h0152;
    mem[1] = 16'hD000;
    run_instr(3);
    check_eq("wait_next_addr", 32'(mem_addr), 32'd1);

    // Branch add wraps below zero
    do_reset();
    mem[0] = 16'hCE80;
    run_instr(0);
    check_eq("br_wrap_addr", 32'(mem_addr), 32'hFF81);

    // Halt
    do_reset();
    mem[0] = 16'hFFFF;
    run_instr(0);

    // Reset aborts an ADD in EXEC after C was set
    do_reset();
    mem[0] = 16'h0152;
    mem[1] = 16'h0152;
    use_fixed = 1'b1;
    fixed_flags = 5'b00001;
    run_instr(0);
    use_fixed = 1'b0;
    check_eq("cin_before_abort", 32'(cin), 32'd1);
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("abort_in_exec_opcode", 32'(opcode), 32'h0152);
    rst_n = 1'b0;
    #1;
    check_eq("abort_reg_write", 32'(reg_write), 32'd0);
    check_eq("abort_mem_read", 32'(mem_read), 32'd0);
    check_eq("abort_pc", 32'(pc), 32'd0);
    check_eq("abort_cin", 32'(cin), 32'd0);
    check_eq("abort_opcode", 32'(opcode), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check_eq("abort_hold_reg_write", 32'(reg_write), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check_eq("abort_rel_mem_read", 32'(mem_read), 32'd1);
    check_eq("abort_rel_addr", 32'(mem_addr), 32'd0);
    check_eq("abort_rel_cin", 32'(cin), 32'd0);
    @(negedge clk);
    check_eq("abort_no_late_write", 32'(reg_write), 32'd0);

    // RESET_PC = FFFF with NOP: PC wraps to 0
    @(negedge clk);
    mem[16'hFFFF] = 16'hD000;
    do_reset();
    check_eq("w_mem_read", 32'(mem_read_w), 32'd1);
    check_eq("w_mem_addr", 32'(mem_addr_w), 32'hFFFF);
    mem_ready = 1'b1;
    @(negedge clk);
    check_eq("w_pc_wrapped", 32'(pc_w), 32'd0);
    check_eq("w_decode_opcode", 32'(opcode_w), 32'hD000);
    @(negedge clk);
    check_eq("w_refetch_read", 32'(mem_read_w), 32'd1);
    check_eq("w_refetch_addr", 32'(mem_addr_w), 32'd0);

    // Random program against the reference model
    for (int a = 0; a < 65536; a++) mem[a] = gen_instr();
    @(negedge clk);
    do_reset();
    repeat (400) run_instr(-1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Multi-cycle fetch/decode/execute controller that sequences the `datapath` block (register file + ALU). It owns the program counter and fetches 16-bit instructions over a simple ready-handshake memory port. It drives the datapath `Opcode` bus, register write-enable and carry-in, and latches the ALU `Flags` for conditional branches. It sits between instruction memory and `datapath` at the top of the CPU.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.

Ports:
- `Clk`  in  1  single system clock; all state changes on rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `MemData`  in  16  instruction word; valid when `MemReady`=1.
- `MemReady`  in  1  memory has `MemData` valid for the current `MemAddr`.
- `Flags`  in  5  ALU flags from datapath: [0]=C, [1]=L, [2]=F, [3]=Z, [4]=N.
- `MemAddr`  out  16  instruction fetch address (= PC).
- `MemRead`  out  1  fetch request.
- `Opcode`  out  16  instruction word to datapath.
- `RegWrite`  out  1  register-file write strobe; gates datapath writeback.
- `Cin`  out  1  carry-in to ALU (latched C flag).
- `Halted`  out  1  sequencer has executed HALT.
- `PC`  out  16  current program counter (debug).

## Operation
- States: FETCH, DECODE, EXEC, WB, HALT.
- FETCH:
  - `MemRead`=1, `MemAddr`=PC.
  - On an edge with `MemReady`=1: IR <= `MemData`, PC <= PC+1, go to DECODE.
  - Otherwise stay in FETCH; PC and IR are unchanged.
- DECODE: classify IR[15:12].
  - 4'h0–4'hB: ALU op, go to EXEC.
  - 4'hC: Bcond, go to EXEC.
  - IR == 16'hFFFF: go to HALT.
  - All other encodings: NOP, go to FETCH.
- EXEC, ALU op:
  - `Opcode`=IR.
  - Flag register <= `Flags` at the end of EXEC.
  - CMP (IR[15:12]=0, IR[7:4]=4'hB) goes to FETCH with no write; all other ALU ops go to WB.
- EXEC, Bcond:
  - Condition from IR[11:8]: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 HI L; 5 LS !L; 6 GT N; 7 LE !N; 8 FS F; 9 FC !F; E UC always; others never.
  - If true: PC <= PC + sext(IR[7:0]), modulo 2^16. PC here is already the incremented value, so disp 8'hFF branches to itself.
  - Flag register unchanged. Go to FETCH.
- WB: `Opcode`=IR, `RegWrite`=1 for exactly this cycle, go to FETCH.
- HALT: absorbing state. `Halted`=1, `MemRead`=0. Exits only via reset.
- `Opcode`:
  - Holds IR in DECODE, EXEC and WB.
  - Is 16'h0000 in FETCH and HALT.
- `Cin` = flag register C bit, in all states.
- Flag register is written only by non-branch ALU ops in EXEC.

## Timing
- Reset (`Reset`=0, async) sets:
  - State FETCH, PC=`RESET_PC`, IR=0, flag register=0.
  - Outputs: `MemRead`=0, `MemAddr`=`RESET_PC`, `Opcode`=0, `RegWrite`=0, `Cin`=0, `Halted`=0.
  - `MemRead` is gated by `Reset`; it rises combinationally when reset releases.
- Reset asserted mid-instruction aborts it immediately. No `RegWrite` pulse follows, and the PC and flag register updates of that instruction are lost.
- Latency with zero-wait memory (`MemReady` high in the first FETCH cycle):
  - ALU write op: 4 cycles.
  - CMP and Bcond: 3 cycles.
  - NOP: 2 cycles.
- Each cycle `MemReady` is low in FETCH adds 1 cycle.
- `MemReady` outside FETCH is ignored.
- `MemAddr` is stable while `MemRead`=1.
- All outputs are registered or decoded from the state register only. There is no combinational path from `MemData`/`Flags` to outputs.
- PC wraps 16'hFFFF -> 16'h0000 on increment and on branch add.

## Test plan
- Reset: hold `Reset`=0 for 3 cycles, then release.
  - During reset: `MemRead`=0, `PC`=0, `Opcode`=0, `Halted`=0.
  - After release: `MemRead`=1 and `MemAddr`=0 in the first cycle.
- ALU op: mem[0]=16'h0152 (ADD r1,r2), zero-wait.
  - `Opcode`=16'h0152 for cycles 2–4.
  - `RegWrite`=1 only in cycle 4.
  - Next fetch at `MemAddr`=1.
- CMP then branch: mem[0]=16'h01B2, `Flags`=5'b01000 (Z=1) during EXEC; mem[1]=16'hC0FE (BEQ −2).
  - CMP: no `RegWrite`.
  - Branch taken; next fetch at `MemAddr`=0.
  - Repeat with Z=0: branch not taken; next fetch at 2.
- Wait states: `MemReady` low for 3 cycles on a fetch.
  - `MemRead` stays high and `MemAddr` stays stable throughout.
  - PC increments only on the ready edge.
  - Total ALU latency = 7 cycles.
- Halt and wrap:
  - mem[0]=16'hFFFF: `Halted`=1 from cycle 3; `MemRead` stays 0 indefinitely.
  - `RESET_PC`=16'hFFFF with a NOP: next `MemAddr`=16'h0000.
- Reset mid-op: assert `Reset` during the EXEC of ADD.
  - No `RegWrite` pulse.
  - After release, fetch restarts at `RESET_PC` with `Cin`=0.
